ora_tc_controller: RTL and testbench
====================================

// Module: ora_tc_controller
// PURPOSE
//   Control and front-end stage for the transition-count output response analyser (ORA #3) in LBIST.
//   Sequences one BIST session: clears the ORA counter, then steps the pattern generator N times.
//   Detects 0<->1 transitions on the CUT response bit and drives the counter's increment input.
//   Compares the final count against a golden value and reports pass/fail.
//   Sits between the TPG/CUT and the ORA counter: it feeds cnt_clr/cnt_inc and consumes count.
// PARAMETERS
//   BITS       32  width of the ORA counter and of the golden value
//   PCNT_BITS  16  width of the pattern-count register
// PORTS
//   clk           in   1          system clock; all state changes on its rising edge
//   rst           in   1          synchronous, active-high reset
//   start         in   1          starts a session; sampled only in IDLE
//   num_patterns  in   PCNT_BITS  pattern count N; latched when start is accepted
//   golden        in   BITS       expected transition count; latched when start is accepted
//   cut_out       in   1          CUT response bit, sampled every RUN cycle
//   count         in   BITS       current value of the ORA counter
//   cnt_clr       out  1          drives the counter reset
//   cnt_inc       out  1          drives the counter increment; registered
//   tpg_en        out  1          advances the pattern generator by one pattern per cycle
//   busy          out  1          high in every state except IDLE
//   done          out  1          one-cycle pulse when the result is valid
//   pass          out  1          1 when latched count == golden; held until the next start
// BEHAVIOUR
//   Reset values (rst=1 at a clk edge): state=IDLE, cnt_clr=1, cnt_inc=0, tpg_en=0.
//     Also busy=0, done=0, pass=0, prev_out=0, pattern counter=0.
//     cnt_clr=1 in reset also clears the downstream counter.
//   States and transitions:
//     IDLE -> CLEAR on start=1; latch N and golden.
//     CLEAR: one cycle; cnt_clr=1; prev_out<=0; pattern counter<=0.
//       Go to RUN if N!=0, else to FLUSH.
//     RUN: tpg_en=1; prev_out<=cut_out; pattern counter +1 per cycle.
//       After exactly N RUN cycles, go to FLUSH.
//     FLUSH: one cycle; lets the last cnt_inc land in the counter.
//     COMPARE: one cycle; pass<=(count==golden).
//     DONE: one cycle; done=1; then IDLE.
//   Outputs cnt_clr, tpg_en, busy and done decode from the state register.
//     cnt_clr is also 1 during reset.
//   Transition detect:
//     cnt_inc <= (state==RUN) && (cut_out != prev_out).
//     prev_out is 0 at the first RUN cycle, so a leading 1 counts as a transition.
//     cnt_inc is 0 in every non-RUN cycle after the FLUSH cycle.
//   Latency: start accepted at edge k -> CLEAR in cycle k+1 -> RUN in k+2..k+N+1.
//     Then FLUSH k+N+2, COMPARE k+N+3, DONE (done=1, pass valid) k+N+4.
//   The counter wraps modulo 2^BITS; the compare uses the wrapped value.
//   start while busy is ignored; N and golden are not re-latched.
//   start held high through DONE starts a new session from the following IDLE cycle.
//   pass is cleared to 0 when a new start is accepted.
//   rst asserted mid-session:
//     Abort to IDLE on the same edge; all outputs take their reset values.
//     No done pulse is produced.
// TESTING
//   1. N=5, cut_out=0,1,1,0,1 in RUN cycles, golden=3 -> count=3; done pulse at k+9; pass=1.
//   2. Same stimulus, golden=4 -> done pulse at k+9; pass=0.
//   3. N=0, golden=0 -> no tpg_en pulses; done at k+4; pass=1.
//   4. BITS=2, N=6, cut_out alternating starting with 1, golden=2 -> count wraps 6 mod 4 = 2; pass=1.
//   5. rst on the 3rd RUN cycle -> next cycle IDLE, busy=0, cnt_clr=1, no done.
//      A following session with N=5, golden=3 and the test 1 stimulus -> pass=1.
//   6. start pulsed again during RUN -> ignored; exactly N tpg_en cycles; one done pulse.

Source files
------------

// File: rtl/ora_tc_controller.sv
// ora_tc_controller
// Session sequencer and transition-detect front end for the transition-count
// output response analyser. One session clears the downstream counter, steps
// the pattern generator N times, and converts each 0<->1 change on the CUT
// response into a counter increment. It then compares the settled count
// against the golden value latched at start.
module ora_tc_controller #(
   parameter int BITS      = 32,
   parameter int PCNT_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [PCNT_BITS-1:0] num_patterns,
   input  logic [BITS-1:0]      golden,
   input  logic                 cut_out,
   input  logic [BITS-1:0]      count,
   output logic                 cnt_clr,
   output logic                 cnt_inc,
   output logic                 tpg_en,
   output logic                 busy,
   output logic                 done,
   output logic                 pass
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      FLUSH   = 3'd3,
      COMPARE = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t               state_reg;
   logic                 prev_out_reg;
   logic [PCNT_BITS-1:0] pcnt_reg;
   logic [PCNT_BITS-1:0] n_reg;
   logic [BITS-1:0]      golden_reg;

   // Session FSM. Every output is registered and is written together with the
   // state it belongs to, so each output always lines up with state_reg.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_clr      <= 1'b1;
         cnt_inc      <= 1'b0;
         tpg_en       <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         prev_out_reg <= 1'b0;
         pcnt_reg     <= '0;
         n_reg        <= '0;
         golden_reg   <= '0;
      end else begin
         // A transition in a RUN cycle becomes an increment one cycle later.
         // The increment from the last RUN cycle lands during FLUSH.
         cnt_inc <= (state_reg == RUN) && (cut_out != prev_out_reg);

         // Defaults: the state-decoded strobes are low unless set below.
         cnt_clr <= 1'b0;
         tpg_en  <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b1;

         case (state_reg)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  state_reg  <= CLEAR;
                  n_reg      <= num_patterns;
                  golden_reg <= golden;
                  pass       <= 1'b0;
                  cnt_clr    <= 1'b1;
                  busy       <= 1'b1;
               end
            end

            CLEAR: begin
               prev_out_reg <= 1'b0;
               pcnt_reg     <= '0;
               if (n_reg != '0) begin
                  state_reg <= RUN;
                  tpg_en    <= 1'b1;
               end else begin
                  state_reg <= FLUSH;
               end
            end

            RUN: begin
               prev_out_reg <= cut_out;
               pcnt_reg     <= pcnt_reg + PCNT_BITS'(1);
               if (pcnt_reg == n_reg - PCNT_BITS'(1)) begin
                  state_reg <= FLUSH;
               end else begin
                  tpg_en <= 1'b1;
               end
            end

            FLUSH: begin
               state_reg <= COMPARE;
            end

            COMPARE: begin
               // The counter has absorbed every increment by now; the
               // comparison uses its wrapped value.
               pass      <= (count == golden_reg);
               state_reg <= DONE;
               done      <= 1'b1;
            end

            DONE: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
            end

            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ora_tc_controller.sv
// Directed bench for ora_tc_controller. It uses two instances: one with the
// default 32-bit counter and one with a 2-bit counter for the wrap case. Each
// instance drives a small behavioural ORA counter.
module tb_ora_tc_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [15:0] num_patterns;
   logic [31:0] golden;
   logic        cut_out;

   logic [31:0] count_a;
   logic [1:0]  count_b;
   logic cnt_clr_a, cnt_inc_a, tpg_en_a, busy_a, done_a, pass_a;
   logic cnt_clr_b, cnt_inc_b, tpg_en_b, busy_b, done_b, pass_b;

   logic sel;
   logic obs_clr, obs_inc, obs_tpg, obs_busy, obs_done, obs_pass;
   logic [31:0] obs_count;

   int checks   = 0;
   int failures = 0;
   int done_seen = 0;

   always #5 clk = ~clk;

   ora_tc_controller #(.BITS(32), .PCNT_BITS(16)) dut (
      .clk(clk), .rst(rst), .start(start_a), .num_patterns(num_patterns),
      .golden(golden), .cut_out(cut_out), .count(count_a),
      .cnt_clr(cnt_clr_a), .cnt_inc(cnt_inc_a), .tpg_en(tpg_en_a),
      .busy(busy_a), .done(done_a), .pass(pass_a)
   );

   ora_tc_controller #(.BITS(2), .PCNT_BITS(16)) dut2 (
      .clk(clk), .rst(rst), .start(start_b), .num_patterns(num_patterns),
      .golden(golden[1:0]), .cut_out(cut_out), .count(count_b),
      .cnt_clr(cnt_clr_b), .cnt_inc(cnt_inc_b), .tpg_en(tpg_en_b),
      .busy(busy_b), .done(done_b), .pass(pass_b)
   );

   // Downstream ORA counters fed by each controller.
   always_ff @(posedge clk) begin
      if (cnt_clr_a) count_a <= '0;
      else if (cnt_inc_a) count_a <= count_a + 32'd1;
      if (cnt_clr_b) count_b <= '0;
      else if (cnt_inc_b) count_b <= count_b + 2'd1;
   end

   assign obs_clr   = sel ? cnt_clr_b : cnt_clr_a;
   assign obs_inc   = sel ? cnt_inc_b : cnt_inc_a;
   assign obs_tpg   = sel ? tpg_en_b  : tpg_en_a;
   assign obs_busy  = sel ? busy_b    : busy_a;
   assign obs_done  = sel ? done_b    : done_a;
   assign obs_pass  = sel ? pass_b    : pass_a;
   assign obs_count = sel ? {30'd0, count_b} : count_a;

   // Counts done pulses, sampled just before each rising edge.
   always @(posedge clk) begin
      if (obs_done === 1'b1) done_seen++;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One full session on the selected instance; pulse_at >= 0 re-pulses start
   // during that RUN cycle with different N/golden, which must be ignored.
   task automatic session(input string tag, input logic s, input int n,
                          input logic [31:0] g, input logic [15:0] pat,
                          input logic [31:0] exp_cnt, input logic exp_pass,
                          input int pulse_at);
      int d0;
      int tpg_cycles;
      d0 = done_seen;
      tpg_cycles = 0;
      sel = s;
      @(negedge clk);
      if (s) start_b = 1'b1; else start_a = 1'b1;
      num_patterns = n[15:0];
      golden = g;
      cut_out = 1'b0;
      @(negedge clk);                          // CLEAR cycle
      start_a = 1'b0;
      start_b = 1'b0;
      num_patterns = 16'hFFFF;
      golden = 32'hFFFF_FFFF;
      check({tag, "_clear_busy"}, 32'(obs_busy), 32'd1);
      check({tag, "_clear_clr"},  32'(obs_clr),  32'd1);
      check({tag, "_clear_tpg"},  32'(obs_tpg),  32'd0);
      check({tag, "_clear_pass"}, 32'(obs_pass), 32'd0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);                       // RUN cycle i
         if (obs_tpg === 1'b1) tpg_cycles++;
         cut_out = pat[i];
         if (i == pulse_at) begin
            if (s) start_b = 1'b1; else start_a = 1'b1;
         end else begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
      end
      @(negedge clk);                          // FLUSH
      start_a = 1'b0;
      start_b = 1'b0;
      cut_out = 1'b0;
      check({tag, "_tpg_cycles"}, 32'(tpg_cycles), 32'(n));
      check({tag, "_flush_tpg"},  32'(obs_tpg),  32'd0);
      check({tag, "_flush_done"}, 32'(obs_done), 32'd0);
      @(negedge clk);                          // COMPARE
      check({tag, "_count"},      obs_count,      exp_cnt);
      check({tag, "_cmp_inc"},    32'(obs_inc),   32'd0);
      @(negedge clk);                          // DONE
      check({tag, "_done"},       32'(obs_done), 32'd1);
      check({tag, "_pass"},       32'(obs_pass), 32'(exp_pass));
      @(negedge clk);                          // back in IDLE
      check({tag, "_idle_busy"},  32'(obs_busy), 32'd0);
      check({tag, "_idle_done"},  32'(obs_done), 32'd0);
      check({tag, "_pass_held"},  32'(obs_pass), 32'(exp_pass));
      check({tag, "_done_pulses"}, 32'(done_seen - d0), 32'd1);
      $display("session %s N=%0d golden=%0d count=%0d pass=%0b", tag, n, g, obs_count, obs_pass);
   endtask

   initial begin
      int d0;
      rst = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      num_patterns = '0;
      golden = '0;
      cut_out = 1'b0;
      sel = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy_a),    32'd0);
      check("rst_clr",  32'(cnt_clr_a), 32'd1);
      check("rst_tpg",  32'(tpg_en_a),  32'd0);
      check("rst_inc",  32'(cnt_inc_a), 32'd0);
      check("rst_done", 32'(done_a),    32'd0);
      check("rst_pass", 32'(pass_a),    32'd0);
      check("rst_count", count_a,       32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_clr", 32'(cnt_clr_a), 32'd0);
      $display("reset done");

      // 1: N=5, cut_out 0,1,1,0,1 -> 3 transitions
      session("t1", 1'b0, 5, 32'd3, 16'b10110, 32'd3, 1'b1, -1);
      // 2: same stimulus, wrong golden
      session("t2", 1'b0, 5, 32'd4, 16'b10110, 32'd3, 1'b0, -1);
      // 3: N=0
      session("t3", 1'b0, 0, 32'd0, 16'b0, 32'd0, 1'b1, -1);
      // 4: 2-bit counter, alternating 1,0,1,0,1,0 -> 6 mod 4 = 2
      session("t4", 1'b1, 6, 32'd2, 16'b010101, 32'd2, 1'b1, -1);

      // 5: reset during the 3rd RUN cycle
      sel = 1'b0;
      d0 = done_seen;
      @(negedge clk);
      start_a = 1'b1;
      num_patterns = 16'd5;
      golden = 32'd3;
      @(negedge clk);                          // CLEAR
      start_a = 1'b0;
      @(negedge clk);                          // RUN 0
      cut_out = 1'b0;
      @(negedge clk);                          // RUN 1
      cut_out = 1'b1;
      @(negedge clk);                          // RUN 2
      cut_out = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy_a),    32'd0);
      check("abort_clr",  32'(cnt_clr_a), 32'd1);
      check("abort_tpg",  32'(tpg_en_a),  32'd0);
      check("abort_inc",  32'(cnt_inc_a), 32'd0);
      check("abort_pass", 32'(pass_a),    32'd0);
      repeat (10) @(negedge clk);
      check("abort_no_done", 32'(done_seen - d0), 32'd0);
      check("abort_idle",    32'(busy_a),         32'd0);
      $display("session t5_abort reset on RUN cycle 3 busy=%0b", busy_a);
      session("t5", 1'b0, 5, 32'd3, 16'b10110, 32'd3, 1'b1, -1);

      // 6: start re-pulsed during RUN is ignored
      session("t6", 1'b0, 5, 32'd3, 16'b10110, 32'd3, 1'b1, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
